// File: rtl/stats_pkg.sv
// Shared definitions for the pet stat scheduler and stat datapath:
// stat indices, op encodings, scheduler states and index helpers.
package stats_pkg;

    localparam int unsigned NUM_STATS = 5;

    localparam logic [2:0] STAT_HUNGER    = 3'd0;
    localparam logic [2:0] STAT_HAPPINESS = 3'd1;
    localparam logic [2:0] STAT_HEALTH    = 3'd2;
    localparam logic [2:0] STAT_HYGIENE   = 3'd3;
    localparam logic [2:0] STAT_ENERGY    = 3'd4;

    localparam logic OP_DEC = 1'b0;
    localparam logic OP_INC = 1'b1;

    typedef enum logic {
        IDLE,
        ISSUE
    } sched_state_e;

    // Folds 0..9 onto a stat index 0..4.
    function automatic logic [2:0] stat_mod5(input logic [3:0] v);
        return (v < 4'd5) ? v[2:0] : 3'(v - 4'd5);
    endfunction

    function automatic logic [2:0] stat_wrap_inc(input logic [2:0] s);
        return (s == STAT_ENERGY) ? STAT_HUNGER : s + 3'd1;
    endfunction

endpackage

// File: rtl/stat_lfsr.sv
// 5-bit maximal-length LFSR advancing every cycle, with its state folded
// onto a stat index 0..4 for random stat selection.
module stat_lfsr
    import stats_pkg::*;
#(
    parameter logic [4:0] SEED = 5'h1F
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [2:0] rand_sel_o
);

    logic [4:0] lfsr_q;
    logic [4:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rand_sel_o = stat_mod5({1'b0, lfsr_q[2:0]});

endmodule

// File: rtl/stat_scheduler.sv
// Serialises decay ticks and round-robin care requests onto a single
// valid/ready command port towards the stat datapath.
module stat_scheduler
    import stats_pkg::*;
#(
    parameter int unsigned TICK_CYCLES     = 10_000_000,
    parameter int unsigned COOLDOWN_CYCLES = 2_700_000,
    parameter logic [4:0]  LFSR_SEED       = 5'h1F
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_STATS-1:0] care_req,
    input  logic                 cmd_ready,
    output logic                 cmd_valid,
    output logic                 cmd_inc,
    output logic [2:0]           cmd_sel,
    output logic [NUM_STATS-1:0] pending,
    output logic                 cooldown_active,
    output logic                 decay_overrun
);

    localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned CW = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

    sched_state_e         state_q;
    logic                 cmd_valid_q, cmd_inc_q;
    logic [2:0]           cmd_sel_q;
    logic [TW-1:0]        tick_q, tick_d;
    logic [CW-1:0]        cool_q, cool_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [NUM_STATS-1:0] prev_q, pend_q, pend_d;
    logic                 decay_pending_q, decay_pending_d;
    logic [2:0]           decay_sel_q, decay_sel_d;
    logic                 decay_overrun_q, decay_overrun_d;

    logic                 tick, take_decay, take_care, care_done;
    logic                 grant_found;
    logic [2:0]           grant_sel, idx, rand_sel;
    logic [3:0]           sum;
    logic [NUM_STATS-1:0] set_mask, clr_mask;

    stat_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i      (clk),
        .rst_i      (reset),
        .rand_sel_o (rand_sel)
    );

    assign tick = (tick_q == TW'(TICK_CYCLES - 1));

    always_comb begin
        grant_found = 1'b0;
        grant_sel   = rr_ptr_q;
        idx         = rr_ptr_q;
        sum         = '0;
        for (int unsigned i = 0; i < NUM_STATS; i++) begin
            sum = {1'b0, rr_ptr_q} + 4'(i);
            idx = stat_mod5(sum);
            if (!grant_found && pend_q[idx]) begin
                grant_found = 1'b1;
                grant_sel   = idx;
            end
        end

        take_decay = (state_q == IDLE) && decay_pending_q;
        take_care  = (state_q == IDLE) && !decay_pending_q && grant_found && (cool_q == '0);
        care_done  = (state_q == ISSUE) && cmd_ready && (cmd_inc_q == OP_DEC);

        // A new edge on a bit being granted this cycle must survive the clear.
        set_mask = cooldown_active ? '0 : (care_req & ~prev_q);
        clr_mask = '0;
        if (take_care) begin
            clr_mask[grant_sel] = 1'b1;
        end
        pend_d = (pend_q & ~clr_mask) | set_mask;

        tick_d          = tick ? '0 : tick_q + 1'b1;
        decay_pending_d = tick ? 1'b1 : (take_decay ? 1'b0 : decay_pending_q);
        decay_sel_d     = tick ? rand_sel : decay_sel_q;
        decay_overrun_d = decay_overrun_q | (tick && decay_pending_q && !take_decay);
        rr_ptr_d        = care_done ? stat_wrap_inc(cmd_sel_q) : rr_ptr_q;
        if (care_done) begin
            cool_d = CW'(COOLDOWN_CYCLES);
        end else if (cool_q != '0) begin
            cool_d = cool_q - 1'b1;
        end else begin
            cool_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q          <= '0;
            cool_q          <= '0;
            rr_ptr_q        <= STAT_HUNGER;
            prev_q          <= '0;
            pend_q          <= '0;
            decay_pending_q <= 1'b0;
            decay_sel_q     <= STAT_HUNGER;
            decay_overrun_q <= 1'b0;
        end else begin
            tick_q          <= tick_d;
            cool_q          <= cool_d;
            rr_ptr_q        <= rr_ptr_d;
            prev_q          <= care_req;
            pend_q          <= pend_d;
            decay_pending_q <= decay_pending_d;
            decay_sel_q     <= decay_sel_d;
            decay_overrun_q <= decay_overrun_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            cmd_inc_q   <= OP_DEC;
            cmd_sel_q   <= STAT_HUNGER;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_decay) begin
                        cmd_inc_q   <= OP_INC;
                        cmd_sel_q   <= decay_sel_q;
                        cmd_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end else if (take_care) begin
                        cmd_inc_q   <= OP_DEC;
                        cmd_sel_q   <= grant_sel;
                        cmd_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_valid       = cmd_valid_q;
    assign cmd_inc         = cmd_inc_q;
    assign cmd_sel         = cmd_sel_q;
    assign pending         = pend_q;
    assign cooldown_active = (cool_q != '0);
    assign decay_overrun   = decay_overrun_q;

endmodule

// File: tb/tb_stat_scheduler.sv
// Directed bench for stat_scheduler with short tick/cooldown periods; command
// contents are scoreboarded against a reference tick/LFSR model and care order.
module tb_stat_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] care_req = '0;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid, cmd_inc, cooldown_active, decay_overrun;
    logic [2:0] cmd_sel;
    logic [4:0] pending;

    stat_scheduler #(
        .TICK_CYCLES     (16),
        .COOLDOWN_CYCLES (8),
        .LFSR_SEED       (5'h1F)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .care_req        (care_req),
        .cmd_ready       (cmd_ready),
        .cmd_valid       (cmd_valid),
        .cmd_inc         (cmd_inc),
        .cmd_sel         (cmd_sel),
        .pending         (pending),
        .cooldown_active (cooldown_active),
        .decay_overrun   (decay_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_decay = 0;

    typedef struct {
        int         cyc;
        logic [2:0] sel;
    } dec_t;

    dec_t       exp_decay[$];
    int         exp_care[$];
    dec_t       dnew, dexp;
    int         cexp;
    logic [4:0] mlfsr;
    int         mcnt;

    function automatic logic [2:0] ref_sel(input logic [4:0] l);
        logic [2:0] v;
        v = l[2:0];
        return (v < 3'd5) ? v : v - 3'd5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp))
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic at(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference tick counter and LFSR; each tick queues the expected decay target.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc   <= 0;
            mcnt  <= 0;
            mlfsr <= 5'h1F;
            exp_decay.delete();
        end else begin
            cyc <= cyc + 1;
            if (mcnt == 15) begin
                mcnt     <= 0;
                dnew.cyc = cyc;
                dnew.sel = ref_sel(mlfsr);
                exp_decay.push_back(dnew);
            end else begin
                mcnt <= mcnt + 1;
            end
            mlfsr <= {mlfsr[3:0], mlfsr[4] ^ mlfsr[2]};
        end
    end

    always @(negedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            if (cmd_inc) begin
                n_decay++;
                // A tick superseded by a later one (while still pending) is lost.
                while (exp_decay.size() > 1 && exp_decay[1].cyc <= cyc - 2)
                    void'(exp_decay.pop_front());
                checks++;
                assert (exp_decay.size() != 0)
                else begin
                    failures++;
                    $error("FAIL decay_unexpected: observed sel=%0d expected no decay command", cmd_sel);
                end
                if (exp_decay.size() != 0) begin
                    dexp = exp_decay.pop_front();
                    chk("decay_sel", 32'(cmd_sel), int'(dexp.sel));
                end
            end else begin
                checks++;
                assert (exp_care.size() != 0)
                else begin
                    failures++;
                    $error("FAIL care_unexpected: observed sel=%0d expected no care command", cmd_sel);
                end
                if (exp_care.size() != 0) begin
                    cexp = exp_care.pop_front();
                    chk("care_sel", 32'(cmd_sel), cexp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected TB_RESULT before 100000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(cmd_valid), 0);
        chk("rst_inc", 32'(cmd_inc), 0);
        chk("rst_sel", 32'(cmd_sel), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_cooldown", 32'(cooldown_active), 0);
        chk("rst_overrun", 32'(decay_overrun), 0);

        at(15); chk("tick_valid15", 32'(cmd_valid), 0);
        at(16); chk("tick_valid16", 32'(cmd_valid), 0);
        at(17); chk("tick_valid17", 32'(cmd_valid), 1); chk("tick_inc17", 32'(cmd_inc), 1);
        at(18); chk("tick_gap18", 32'(cmd_valid), 0);
        at(70); chk("decay_count", 32'(n_decay), 4);

        at(84); care_req = 5'b00100; exp_care.push_back(2);
        at(85); chk("care_pend", 32'(pending), 5'b00100); care_req = '0;
        at(86); chk("care_valid", 32'(cmd_valid), 1); chk("care_inc", 32'(cmd_inc), 0);
                chk("care_sel86", 32'(cmd_sel), 2); chk("cool86", 32'(cooldown_active), 0);
        at(87); chk("cool87", 32'(cooldown_active), 1);
        at(88); care_req = 5'b00100;
        at(89); chk("edge_dropped", 32'(pending), 0); care_req = '0;
        at(94); chk("cool94", 32'(cooldown_active), 1);
        at(95); chk("cool95", 32'(cooldown_active), 0);

        at(100); care_req = 5'b01000;
        at(101); cmd_ready = 1'b0; care_req = 5'b00001;
        at(102); chk("stall_valid102", 32'(cmd_valid), 1); chk("stall_sel102", 32'(cmd_sel), 3);
                 chk("pend102", 32'(pending), 5'b00001);
        at(103); reset = 1'b1; #1;
        chk("mid_rst_valid", 32'(cmd_valid), 0);
        chk("mid_rst_inc", 32'(cmd_inc), 0);
        chk("mid_rst_sel", 32'(cmd_sel), 0);
        chk("mid_rst_pending", 32'(pending), 0);
        chk("mid_rst_cooldown", 32'(cooldown_active), 0);
        chk("mid_rst_overrun", 32'(decay_overrun), 0);
        cmd_ready = 1'b1; care_req = '0;
        @(negedge clk);
        reset = 1'b0;
        #1;

        chk("r2_pending0", 32'(pending), 0);
        at(15); chk("r2_valid15", 32'(cmd_valid), 0);
        at(16); chk("r2_valid16", 32'(cmd_valid), 0);
        at(17); chk("r2_valid17", 32'(cmd_valid), 1); chk("r2_inc17", 32'(cmd_inc), 1);

        at(20); care_req = 5'b11001; exp_care.push_back(0); exp_care.push_back(3); exp_care.push_back(4);
        at(21); chk("rr_pend21", 32'(pending), 5'b11001);
        at(22); chk("rr_valid22", 32'(cmd_valid), 1); chk("rr_sel22", 32'(cmd_sel), 0);
                chk("rr_inc22", 32'(cmd_inc), 0); chk("rr_pend22", 32'(pending), 5'b11000);
        at(23); care_req = '0;
        at(32); chk("rr_valid32", 32'(cmd_valid), 1); chk("rr_sel32", 32'(cmd_sel), 3);
                chk("rr_inc32", 32'(cmd_inc), 0);
        at(34); chk("rr_decay34", 32'(cmd_valid), 1); chk("rr_inc34", 32'(cmd_inc), 1);
        at(42); chk("rr_valid42", 32'(cmd_valid), 1); chk("rr_sel42", 32'(cmd_sel), 4);
                chk("rr_pend42", 32'(pending), 0);
        at(52); care_req = 5'b10010; exp_care.push_back(1); exp_care.push_back(4);
        at(53); chk("rr_pend53", 32'(pending), 5'b10010);
        at(54); chk("rr_sel54", 32'(cmd_sel), 1); chk("rr_valid54", 32'(cmd_valid), 1); care_req = '0;
        at(64); chk("rr_sel64", 32'(cmd_sel), 4); chk("rr_valid64", 32'(cmd_valid), 1);
        at(66); chk("rr_decay66", 32'(cmd_inc), 1); chk("rr_valid66", 32'(cmd_valid), 1);

        at(74); care_req = 5'b00100; exp_care.push_back(2);
        at(75); cmd_ready = 1'b0;
        for (int k = 76; k <= 97; k++) begin
            at(k);
            chk("bp_valid", 32'(cmd_valid), 1);
            chk("bp_sel", 32'(cmd_sel), 2);
            chk("bp_inc", 32'(cmd_inc), 0);
            if (k == 77) care_req = '0;
            if (k == 78) begin
                care_req = 5'b00001;
                exp_care.push_back(0);
            end
            if (k == 80) begin
                chk("bp_pend80", 32'(pending), 5'b00001);
                care_req = '0;
            end
            if (k == 95) chk("overrun95", 32'(decay_overrun), 0);
            if (k == 96) chk("overrun96", 32'(decay_overrun), 1);
        end
        at(98); cmd_ready = 1'b1;
        at(99); chk("bp_gap99", 32'(cmd_valid), 0);
        at(100); chk("prio_valid100", 32'(cmd_valid), 1); chk("prio_inc100", 32'(cmd_inc), 1);
                 chk("prio_pend100", 32'(pending), 5'b00001);
        at(108); chk("care_valid108", 32'(cmd_valid), 1); chk("care_sel108", 32'(cmd_sel), 0);
                 chk("care_inc108", 32'(cmd_inc), 0);
        at(110); chk("overrun_sticky110", 32'(decay_overrun), 1);

        at(127); care_req = 5'b00010; exp_care.push_back(1);
        at(128); chk("sc_pend128", 32'(pending), 5'b00010); care_req = '0;
        at(129); chk("sc_decay129", 32'(cmd_valid), 1); chk("sc_inc129", 32'(cmd_inc), 1);
        at(130); care_req = 5'b00010; exp_care.push_back(1);
        at(131); chk("sc_valid131", 32'(cmd_valid), 1); chk("sc_sel131", 32'(cmd_sel), 1);
                 chk("sc_pend131", 32'(pending), 5'b00010); chk("sc_cool131", 32'(cooldown_active), 0);
                 care_req = '0;
        at(132); chk("sc_cool132", 32'(cooldown_active), 1);
        at(141); chk("sc_valid141", 32'(cmd_valid), 1); chk("sc_sel141", 32'(cmd_sel), 1);
                 chk("sc_inc141", 32'(cmd_inc), 0);
        at(142); chk("sc_pend142", 32'(pending), 0);
        at(150);
        chk("care_queue_empty", 32'(exp_care.size()), 0);
        chk("decay_queue_empty", 32'(exp_decay.size()), 0);
        chk("overrun_sticky150", 32'(decay_overrun), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stat_scheduler.md
Name: stat_scheduler

Overview:
Sequences all updates to the pet stat registers (hunger, happiness, health, hygiene, energy) through a single valid/ready command port, so no stat is ever driven by two sources.
- Generates the periodic decay tick and the pseudo-random choice of which stat grows.
- Latches care-button requests, arbitrates them round-robin, and rate-limits care with a cooldown.
- Sits between the debounced button inputs and the stat datapath.

Parameters:
NUM_STATS, 5, number of stats; fixed at 5 in this revision.
TICK_CYCLES, 10_000_000, clk cycles per decay tick.
COOLDOWN_CYCLES, 2_700_000, clk cycles during which care is blocked after a care command is accepted.
LFSR_SEED, 5'h1F, LFSR reset value; must be non-zero.

Ports:
clk  in  1  27 MHz system clock
reset  in  1  asynchronous, active-high reset
care_req  in  5  level care buttons, already synchronised and debounced; bit i = stat i
cmd_ready  in  1  stat datapath accepts the command this cycle
cmd_valid  out  1  command present
cmd_inc  out  1  1 = increment stat (decay); 0 = decrement stat (care)
cmd_sel  out  3  stat index 0..4
pending  out  5  care requests latched but not yet granted
cooldown_active  out  1  cooldown counter non-zero
decay_overrun  out  1  sticky; a decay tick was lost

Behaviour:
- Reset (async, immediate): cmd_valid=0, cmd_inc=0, cmd_sel=0, pending=0, cooldown_active=0, decay_overrun=0. Internal reset values: tick counter=0, cooldown counter=0, rr_ptr=0, edge register=0, decay_pending=0, LFSR=LFSR_SEED, FSM=IDLE.
- Tick counter:
  - counts 0..TICK_CYCLES-1 and wraps;
  - tick fires in the cycle where count==TICK_CYCLES-1.
- LFSR:
  - 5-bit; next = {lfsr[3:0], lfsr[4]^lfsr[2]}; advances every cycle.
  - Never reaches 0.
  - Random stat r = lfsr[2:0] if <5, else lfsr[2:0]-5.
- Decay:
  - On tick, at the next edge decay_pending<=1 and decay_sel<=r (r sampled in the tick cycle).
  - If decay_pending is already 1 on a tick: decay_overrun<=1 (sticky until reset) and decay_sel is replaced.
- Care:
  - Rising edge of care_req[i] (care_req & ~prev) sets pending[i] at the next edge.
  - An edge is dropped if cooldown_active=1 in the edge cycle.
  - If an edge and a grant of the same bit occur in the same cycle, the set wins.
- FSM:
  - IDLE:
    - if decay_pending: load cmd (inc=1, sel=decay_sel), clear decay_pending, go to ISSUE.
    - else if pending!=0 and cooldown counter==0: grant the first set bit searching from rr_ptr upward mod 5; load cmd (inc=0, sel=grant); clear that pending bit; go to ISSUE.
    - Decay has strict priority over care.
  - ISSUE:
    - cmd_valid=1; cmd_inc and cmd_sel are held stable until cmd_valid&cmd_ready.
    - On handshake: go to IDLE and cmd_valid<=0.
    - If the accepted command was care: rr_ptr<=(sel+1) mod 5 and cooldown counter<=COOLDOWN_CYCLES.
  - At least one cycle with cmd_valid=0 separates consecutive commands.
- Cooldown:
  - Counter decrements to 0 by 1 per cycle.
  - cooldown_active=(counter!=0).
  - Blocks care grants and care edges only; decay commands are unaffected.
- Latency, with cmd_ready=1:
  - tick cycle T → cmd_valid high in cycle T+2, accepted in T+2.
  - care_req rises in cycle N → pending[i] at N+1 → cmd_valid at N+2.
- Reset mid-ISSUE: the command is abandoned; no replay after reset.

Decomposition:
- Shared package stats_pkg:
  - NUM_STATS;
  - stat indices STAT_HUNGER=0, STAT_HAPPINESS=1, STAT_HEALTH=2, STAT_HYGIENE=3, STAT_ENERGY=4;
  - op encodings OP_DEC=0, OP_INC=1;
  - FSM state enum {IDLE, ISSUE}.
- One sub-module: stat_lfsr (5-bit LFSR plus the mod-5 mapping, seed parameter). The stats datapath shares it.

Test Plan:
Bench runs with TICK_CYCLES=16 and COOLDOWN_CYCLES=8.
- Reset: assert reset mid-run with cmd_valid=1 → all outputs 0 in the same cycle; after release, first tick at cycle 15, cmd_valid at cycle 17.
- Decay: cmd_ready=1, no buttons → one command every 16 cycles with cmd_inc=1 and cmd_sel equal to the reference-model LFSR mapping (sel always in 0..4).
- Care plus cooldown:
  - care_req[2] rises at cycle N → cmd_valid at N+2 with inc=0, sel=2;
  - cooldown_active high for 8 cycles;
  - a care_req[2] edge at N+4 is dropped (pending stays 0).
- Round-robin:
  - care_req[0], [3], [4] rise together → grants sel=0, then 3, then 4, each after cooldown expires; rr_ptr ends at 0;
  - then [4] and [1] rise together → sel=1 first.
- Backpressure and priority:
  - cmd_ready=0 on a care command → cmd_sel/cmd_inc stable; a tick during the stall sets decay_pending;
  - after release, the decay command is issued before any pending care;
  - a second tick while decay_pending=1 → decay_overrun=1.
- Simultaneous set/clear: care_req[1] edge in the same cycle pending[1] is granted → pending[1]=1 afterward; a second sel=1 command follows once cooldown expires.
